subword_mem_ctrl: RTL and testbench

Sequencer for word-only data memory that executes LW/LH/LB/SW/SH/SB requests from the pipeline's memory stage. Sub-word stores are handled as read-modify-write: read word, merge lane, write back. Sub-word loads are lane-extracted and sign-extended. The block owns the memory port and handles one request at a time, with valid/ready handshakes on both request and response sides.

---
 rtl/subword_mem_pkg.sv | 53 +++++
 rtl/subword_lane_unit.sv | 62 ++++++
 rtl/subword_mem_ctrl.sv | 133 +++++++++++++
 tb/tb_subword_mem_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/subword_mem_pkg.sv
// Shared opcodes, FSM encoding, lane constants and decode helpers for the sub-word memory sequencer.
// LBU/LHU are only accepted when SUBWORD_UNSIGNED_EN is defined.
package subword_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam int   LANE_W    = 8;
  localparam int   HALF_W    = 16;
  localparam int   NUM_LANES = 4;
  localparam logic HALF_LO   = 1'b0;
  localparam logic HALF_HI   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_RESP
  } state_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW: return 1'b1;
`ifdef SUBWORD_UNSIGNED_EN
      OP_LBU, OP_LHU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_aligned(input logic [5:0] op, input logic [1:0] addr_lo);
    case (op)
      OP_LW, OP_SW:         return (addr_lo == 2'b00);
      OP_LH, OP_SH, OP_LHU: return (addr_lo[0] == 1'b0);
      default:              return 1'b1;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/subword_lane_unit.sv
// Combinational lane logic: merges store data into a word and extracts/extends load lanes.
// Zero-extending LBU/LHU extraction exists only when SUBWORD_UNSIGNED_EN is defined.
module subword_lane_unit
  import subword_mem_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] merge_word,
  input  logic [31:0] load_word,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  // Each byte lane independently picks store data or the previously read byte.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic              hit;
      logic [LANE_W-1:0] src;

      always_comb begin
        hit = 1'b0;
        src = store_data[gi*LANE_W +: LANE_W];
        case (op)
          OP_SB: begin
            hit = (addr_lo == 2'(gi));
            src = store_data[LANE_W-1:0];
          end
          OP_SH: begin
            hit = (addr_lo[1] == ((gi / 2 == 1) ? HALF_HI : HALF_LO));
            src = store_data[(gi % 2)*LANE_W +: LANE_W];
          end
          OP_SW:   hit = 1'b1;
          default: hit = 1'b0;
        endcase
      end

      assign merged[gi*LANE_W +: LANE_W] = hit ? src : merge_word[gi*LANE_W +: LANE_W];
    end
  endgenerate

  logic [LANE_W-1:0] sel_byte;
  logic [HALF_W-1:0] sel_half;

  assign sel_byte = load_word[{addr_lo, 3'b000} +: LANE_W];
  assign sel_half = (addr_lo[1] == HALF_HI) ? load_word[31:16] : load_word[15:0];

  always_comb begin
    extracted = load_word;
    case (op)
      OP_LB:   extracted = {{(32-LANE_W){sel_byte[LANE_W-1]}}, sel_byte};
      OP_LH:   extracted = {{(32-HALF_W){sel_half[HALF_W-1]}}, sel_half};
`ifdef SUBWORD_UNSIGNED_EN
      OP_LBU:  extracted = {{(32-LANE_W){1'b0}}, sel_byte};
      OP_LHU:  extracted = {{(32-HALF_W){1'b0}}, sel_half};
`endif
      default: extracted = load_word;
    endcase
  end

endmodule

// File: rtl/subword_mem_ctrl.sv
// One-request-at-a-time sequencer for a word-only memory: sub-word stores via read-modify-write,
// sub-word loads via lane extraction. SUBWORD_UNSIGNED_EN enables LBU/LHU.
module subword_mem_ctrl
  import subword_mem_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam int CNT_W = 3;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [5:0]         op_reg, op_next;
  logic [31:0]        addr_reg, addr_next;
  logic [31:0]        data_reg, data_next;
  logic [31:0]        word_reg, word_next;
  logic [31:0]        resp_data_reg, resp_data_next;
  logic               resp_err_reg, resp_err_next;
  logic [31:0]        merged_word;
  logic [31:0]        extracted_word;

  subword_lane_unit u_lane (
    .op         (op_reg),
    .addr_lo    (addr_reg[1:0]),
    .store_data (data_reg),
    .merge_word (word_reg),
    .load_word  (mem_read_data),
    .merged     (merged_word),
    .extracted  (extracted_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      op_reg        <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
      word_reg      <= '0;
      resp_data_reg <= '0;
      resp_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      op_reg        <= op_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      word_reg      <= word_next;
      resp_data_reg <= resp_data_next;
      resp_err_reg  <= resp_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    op_next        = op_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    word_next      = word_reg;
    resp_data_next = resp_data_reg;
    resp_err_next  = resp_err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          op_next        = req_op;
          addr_next      = req_addr;
          data_next      = req_data;
          resp_data_next = '0;
          resp_err_next  = 1'b0;
          // Rejected requests go straight to the response without touching memory.
          if (!op_supported(req_op) || !op_aligned(req_op, req_addr[1:0])) begin
            resp_err_next = 1'b1;
            state_next    = ST_RESP;
          end else if (req_op == OP_SW) begin
            state_next = ST_WRITE;
          end else begin
            state_next = ST_READ;
          end
        end
      end
      ST_READ: begin
        cnt_next   = CNT_W'(READ_LAT - 1);
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_reg == '0) begin
          word_next = mem_read_data;
          if (op_is_load(op_reg)) begin
            resp_data_next = extracted_word;
            state_next     = ST_RESP;
          end else begin
            state_next = ST_WRITE;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_WRITE: state_next = ST_RESP;
      ST_RESP: begin
        if (resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign req_ready      = (state_reg == ST_IDLE);
  assign mem_read       = (state_reg == ST_READ);
  assign mem_write      = (state_reg == ST_WRITE);
  assign mem_addr       = {addr_reg[31:2], 2'b00};
  assign mem_write_data = (state_reg == ST_WRITE) ? merged_word : '0;
  assign resp_valid     = (state_reg == ST_RESP);
  assign resp_data      = resp_data_reg;
  assign resp_err       = resp_err_reg;

endmodule

// File: tb/tb_subword_mem_ctrl.sv
// Directed bench: two controllers (READ_LAT 1 and 3) share the request stream, each with its own
// latency-modelled memory; timing and data are checked per instance.
module tb_subword_mem_ctrl;
  import subword_mem_pkg::*;

  localparam int LAT [2] = '{1, 3};
  localparam int K_ERR = 0, K_LOAD = 1, K_SUB = 2, K_SW = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [5:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        resp_ready;

  logic        req_ready      [2];
  logic [31:0] mem_addr       [2];
  logic        mem_read       [2];
  logic        mem_write      [2];
  logic [31:0] mem_write_data [2];
  logic [31:0] mem_read_data  [2];
  logic        resp_valid     [2];
  logic [31:0] resp_data      [2];
  logic        resp_err       [2];

  logic [31:0] mem [2][256];
  logic        pv  [2][4];
  logic [31:0] pd  [2][4];
  logic        pl_en = 1'b0;
  logic [31:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  subword_mem_ctrl #(.READ_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .mem_addr(mem_addr[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_write_data(mem_write_data[0]), .mem_read_data(mem_read_data[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready), .resp_data(resp_data[0]),
    .resp_err(resp_err[0])
  );

  subword_mem_ctrl #(.READ_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .mem_addr(mem_addr[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_write_data(mem_write_data[1]), .mem_read_data(mem_read_data[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready), .resp_data(resp_data[1]),
    .resp_err(resp_err[1])
  );

  // Memory model: data shows up READ_LAT cycles after the MemRead cycle, for one cycle only.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pl_en) mem[k][pl_addr[9:2]] <= pl_data;
      else if (mem_write[k]) mem[k][mem_addr[k][9:2]] <= mem_write_data[k];
      pv[k][0] <= mem_read[k];
      pd[k][0] <= mem[k][mem_addr[k][9:2]];
      for (int j = 1; j < 4; j++) begin
        pv[k][j] <= pv[k][j-1];
        pd[k][j] <= pd[k][j-1];
      end
    end
  end

  assign mem_read_data[0] = pv[0][0] ? pd[0][0] : 32'hDEAD_BEEF;
  assign mem_read_data[1] = pv[1][2] ? pd[1][2] : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s/L%0d/req_ready", tag, LAT[k]), 32'(req_ready[k]), 32'd1);
      chk($sformatf("%s/L%0d/mem_read", tag, LAT[k]), 32'(mem_read[k]), 32'd0);
      chk($sformatf("%s/L%0d/mem_write", tag, LAT[k]), 32'(mem_write[k]), 32'd0);
      chk($sformatf("%s/L%0d/mem_addr", tag, LAT[k]), mem_addr[k], 32'd0);
      chk($sformatf("%s/L%0d/mem_wdata", tag, LAT[k]), mem_write_data[k], 32'd0);
      chk($sformatf("%s/L%0d/resp_valid", tag, LAT[k]), 32'(resp_valid[k]), 32'd0);
      chk($sformatf("%s/L%0d/resp_data", tag, LAT[k]), resp_data[k], 32'd0);
      chk($sformatf("%s/L%0d/resp_err", tag, LAT[k]), 32'(resp_err[k]), 32'd0);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = addr; pl_data = val;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // One request with RespReady held high; records strobe/response cycles relative to accept.
  task automatic txn(input string tag, input logic [5:0] op, input logic [31:0] addr,
                     input logic [31:0] data, input int kind, input logic [31:0] exp_rdata,
                     input logic exp_err, input logic [31:0] exp_wdata);
    int rd_c[2], wr_c[2], resp_c[2], nrd[2], nwr[2];
    logic [31:0] ra[2], wa[2], wd[2], rdat[2];
    logic rerr[2], done[2];
    int exp_resp, exp_wr;
    for (int k = 0; k < 2; k++) begin
      rd_c[k] = -1; wr_c[k] = -1; resp_c[k] = -1; nrd[k] = 0; nwr[k] = 0;
      ra[k] = '0; wa[k] = '0; wd[k] = '0; rdat[k] = 'x; rerr[k] = 1'bx; done[k] = 1'b0;
    end
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data; resp_ready = 1'b1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("%s/L%0d/accept_ready", tag, LAT[k]), 32'(req_ready[k]), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 6'b111111; req_addr = 32'hFFFF_FFFF; req_data = 32'h5A5A_5A5A;
    for (int c = 1; c < 20 && !(done[0] && done[1]); c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!done[k]) begin
          if (mem_read[k]) begin nrd[k]++; rd_c[k] = c; ra[k] = mem_addr[k]; end
          if (mem_write[k]) begin
            nwr[k]++; wr_c[k] = c; wa[k] = mem_addr[k]; wd[k] = mem_write_data[k];
          end
          if (resp_valid[k]) begin
            resp_c[k] = c; rdat[k] = resp_data[k]; rerr[k] = resp_err[k]; done[k] = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      case (kind)
        K_ERR:   begin exp_resp = 1;          exp_wr = -1;         end
        K_LOAD:  begin exp_resp = 2 + LAT[k]; exp_wr = -1;         end
        K_SUB:   begin exp_resp = 3 + LAT[k]; exp_wr = 2 + LAT[k]; end
        default: begin exp_resp = 2;          exp_wr = 1;          end
      endcase
      chk($sformatf("%s/L%0d/resp_cycle", tag, LAT[k]), resp_c[k], exp_resp);
      chk($sformatf("%s/L%0d/resp_data", tag, LAT[k]), rdat[k], exp_rdata);
      chk($sformatf("%s/L%0d/resp_err", tag, LAT[k]), 32'(rerr[k]), 32'(exp_err));
      chk($sformatf("%s/L%0d/n_read", tag, LAT[k]), nrd[k],
          (kind == K_LOAD || kind == K_SUB) ? 1 : 0);
      chk($sformatf("%s/L%0d/n_write", tag, LAT[k]), nwr[k], (exp_wr > 0) ? 1 : 0);
      if (nrd[k] == 1) begin
        chk($sformatf("%s/L%0d/read_cycle", tag, LAT[k]), rd_c[k], 1);
        chk($sformatf("%s/L%0d/read_addr", tag, LAT[k]), ra[k], {addr[31:2], 2'b00});
      end
      if (nwr[k] == 1) begin
        chk($sformatf("%s/L%0d/write_cycle", tag, LAT[k]), wr_c[k], exp_wr);
        chk($sformatf("%s/L%0d/write_addr", tag, LAT[k]), wa[k], {addr[31:2], 2'b00});
        chk($sformatf("%s/L%0d/write_data", tag, LAT[k]), wd[k], exp_wdata);
      end
    end
    $display("txn %s op=%b addr=%h data=%h resp L1=%h/%0d L3=%h/%0d", tag, op, addr, data,
             rdat[0], rerr[0], rdat[1], rerr[1]);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_data = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset("reset");
    @(negedge clk) rst_n = 1'b1;

    preload(32'h100, 32'h1122_3344);
    txn("lb_103", OP_LB, 32'h103, 32'h0, K_LOAD, 32'h0000_0011, 1'b0, 32'h0);
    preload(32'h100, 32'h1122_33F4);
    txn("lb_100_neg", OP_LB, 32'h100, 32'h0, K_LOAD, 32'hFFFF_FFF4, 1'b0, 32'h0);
    txn("lbu_100", OP_LBU, 32'h100, 32'h0,
`ifdef SUBWORD_UNSIGNED_EN
        K_LOAD, 32'h0000_00F4, 1'b0,
`else
        K_ERR, 32'h0, 1'b1,
`endif
        32'h0);
    txn("lhu_102", OP_LHU, 32'h102, 32'h0,
`ifdef SUBWORD_UNSIGNED_EN
        K_LOAD, 32'h0000_1122, 1'b0,
`else
        K_ERR, 32'h0, 1'b1,
`endif
        32'h0);

    preload(32'h100, 32'h1122_3344);
    txn("sb_101", OP_SB, 32'h101, 32'hAABB_CCDD, K_SUB, 32'h0, 1'b0, 32'h1122_DD44);
    txn("lw_after_sb", OP_LW, 32'h100, 32'h0, K_LOAD, 32'h1122_DD44, 1'b0, 32'h0);
    preload(32'h100, 32'h1122_3344);
    txn("sh_102", OP_SH, 32'h102, 32'h0000_BEEF, K_SUB, 32'h0, 1'b0, 32'hBEEF_3344);
    txn("lh_102_neg", OP_LH, 32'h102, 32'h0, K_LOAD, 32'hFFFF_BEEF, 1'b0, 32'h0);
    txn("lh_100_pos", OP_LH, 32'h100, 32'h0, K_LOAD, 32'h0000_3344, 1'b0, 32'h0);

    txn("lh_misalign", OP_LH, 32'h101, 32'h0, K_ERR, 32'h0, 1'b1, 32'h0);
    txn("sw_misalign", OP_SW, 32'h102, 32'h1234_5678, K_ERR, 32'h0, 1'b1, 32'h0);
    txn("lw_misalign", OP_LW, 32'h101, 32'h0, K_ERR, 32'h0, 1'b1, 32'h0);
    txn("bad_opcode", 6'b001000, 32'h100, 32'h0, K_ERR, 32'h0, 1'b1, 32'h0);

    txn("sw_200", OP_SW, 32'h200, 32'hCAFE_F00D, K_SW, 32'h0, 1'b0, 32'hCAFE_F00D);
    txn("lw_200", OP_LW, 32'h200, 32'h0, K_LOAD, 32'hCAFE_F00D, 1'b0, 32'h0);
    txn("lb_202", OP_LB, 32'h202, 32'h0, K_LOAD, 32'hFFFF_FFFE, 1'b0, 32'h0);
    txn("sb_203", OP_SB, 32'h203, 32'h0000_0055, K_SUB, 32'h0, 1'b0, 32'h55FE_F00D);
    txn("sh_200", OP_SH, 32'h200, 32'hFFFF_1234, K_SUB, 32'h0, 1'b0, 32'h55FE_1234);
    txn("lh_202", OP_LH, 32'h202, 32'h0, K_LOAD, 32'h0000_55FE, 1'b0, 32'h0);
    txn("lb_201", OP_LB, 32'h201, 32'h0, K_LOAD, 32'h0000_0012, 1'b0, 32'h0);

    // Response backpressure: RespData must hold and no new request may be taken.
    preload(32'h300, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h200; resp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c < 12; c++) begin
      @(negedge clk);
      if (resp_valid[0] && resp_valid[1]) break;
    end
    req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h300; req_data = 32'h0000_0001;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("stall%0d/L%0d/resp_valid", s, LAT[k]), 32'(resp_valid[k]), 32'd1);
        chk($sformatf("stall%0d/L%0d/resp_data", s, LAT[k]), resp_data[k], 32'h55FE_1234);
        chk($sformatf("stall%0d/L%0d/req_ready", s, LAT[k]), 32'(req_ready[k]), 32'd0);
        chk($sformatf("stall%0d/L%0d/mem_write", s, LAT[k]), 32'(mem_write[k]), 32'd0);
      end
      @(negedge clk);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("stall_release/L%0d/req_ready", LAT[k]), 32'(req_ready[k]), 32'd1);
      chk($sformatf("stall_release/L%0d/mem_300", LAT[k]), mem[k][8'hC0], 32'h0);
    end
    $display("txn stall_lw_200 held 3 cycles then released");

    // Reset pulse while both instances are in WAIT of an SB: the write must never happen.
    preload(32'h100, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h100; req_data = 32'h0000_0099;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset("async_reset");
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("post_reset%0d/L%0d/mem_write", c, LAT[k]), 32'(mem_write[k]), 32'd0);
        chk($sformatf("post_reset%0d/L%0d/resp_valid", c, LAT[k]), 32'(resp_valid[k]), 32'd0);
      end
    end
    $display("txn reset_during_wait sb_100 aborted");
    txn("lw_after_reset", OP_LW, 32'h100, 32'h0, K_LOAD, 32'h1122_3344, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
